// File: rtl/cgra_pkg.sv
// Shared CGRA definitions.
// Holds the state encoding used by the register-file drain streamer.
// Widths are not fixed here; every width stays a module parameter.
package cgra_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } rf_drain_state_t;

endpackage

// File: rtl/rf_drain_idx_cnt.sv
// Wrap-around register-file index counter for rf_drain_streamer.
// The load captures the first index and the inclusive word count
// ((last - first) mod DEPTH) + 1. Each advance steps the index modulo DEPTH
// and decrements the count.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   ce_i           clock enable; holds all state when low
//   load_i         load first_i/last_i (takes priority over adv_i)
//   first_i        first index of the range
//   last_i         last index of the range, inclusive
//   adv_i          step to the next index
//   sel_o          current index
//   next_sel_o     index after sel_o, wrapped at DEPTH
//   last_o         current index is the final word of the range
module rf_drain_idx_cnt
  import cgra_pkg::*;
#(
  parameter int unsigned REGFILE_DEPTH = 4,
  parameter int unsigned REGFILE_NSEL  = $clog2(REGFILE_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ce_i,
  input  logic                    load_i,
  input  logic [REGFILE_NSEL-1:0] first_i,
  input  logic [REGFILE_NSEL-1:0] last_i,
  input  logic                    adv_i,
  output logic [REGFILE_NSEL-1:0] sel_o,
  output logic [REGFILE_NSEL-1:0] next_sel_o,
  output logic                    last_o
);

  localparam logic [REGFILE_NSEL:0]   DEPTH_W = (REGFILE_NSEL+1)'(REGFILE_DEPTH);
  localparam logic [REGFILE_NSEL:0]   ONE_W   = (REGFILE_NSEL+1)'(1);
  localparam logic [REGFILE_NSEL-1:0] TOP_IDX = REGFILE_NSEL'(REGFILE_DEPTH - 1);

  logic [REGFILE_NSEL-1:0] sel_q, sel_d;
  logic [REGFILE_NSEL:0]   rem_q, rem_d;
  logic [REGFILE_NSEL:0]   span;

  // The subtract is one bit wider than the index. A wrapped range adds DEPTH
  // back, so the result is correct for depths that are not powers of two.
  always_comb begin
    span = {1'b0, last_i} - {1'b0, first_i};
    if (last_i < first_i) begin
      span = span + DEPTH_W;
    end
  end

  assign next_sel_o = (sel_q == TOP_IDX) ? '0 : sel_q + 1'b1;

  always_comb begin
    sel_d = sel_q;
    rem_d = rem_q;
    if (load_i) begin
      sel_d = first_i;
      rem_d = span + ONE_W;
    end else if (adv_i) begin
      sel_d = next_sel_o;
      rem_d = rem_q - ONE_W;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= '0;
      rem_q <= '0;
    end else if (ce_i) begin
      sel_q <= sel_d;
      rem_q <= rem_d;
    end
  end

  assign sel_o  = sel_q;
  assign last_o = (rem_q == ONE_W);

endmodule

// File: rtl/rf_drain_streamer.sv
// Register-file drain streamer.
// On an accepted start, this block walks the wrap-around index range
// first..last of the register file's parallel bus. It emits one word per
// valid/ready transfer and then pulses done for one enabled cycle.
// Optional feature macro: RF_DRAIN_SNAPSHOT_EN. When it is defined, the
// register file is copied into a shadow bank at start and the stream reads
// that copy. When it is undefined, each word is sampled live as it is loaded.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   ce_i           clock enable; low freezes all state and handshakes
//   start_i        drain request, accepted only in IDLE
//   first_sel_i    first entry index; last_sel_i is the last entry, inclusive
//   regs_i         parallel register-file contents
//   valid_o        output stream valid; ready_i is downstream ready
//   data_o         output word; sel_o is its entry index
//   busy_o         high in STREAM and DONE
//   done_o         pulse after the final transfer
//   err_o          sticky out-of-range index flag, cleared by the next start
module rf_drain_streamer
  import cgra_pkg::*;
#(
  parameter int unsigned REGFILE_DEPTH = 4,
  parameter int unsigned REGFILE_NSEL  = $clog2(REGFILE_DEPTH),
  parameter int unsigned REGFILE_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ce_i,
  input  logic                     start_i,
  input  logic [REGFILE_NSEL-1:0]  first_sel_i,
  input  logic [REGFILE_NSEL-1:0]  last_sel_i,
  input  logic [REGFILE_WIDTH-1:0] regs_i [0:REGFILE_DEPTH-1],
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [REGFILE_WIDTH-1:0] data_o,
  output logic [REGFILE_NSEL-1:0]  sel_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam logic [REGFILE_NSEL:0] DEPTH_W = (REGFILE_NSEL+1)'(REGFILE_DEPTH);

  rf_drain_state_t          state_q, state_d;
  logic                     valid_q, valid_d;
  logic [REGFILE_WIDTH-1:0] data_q, data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     cnt_load, cnt_adv, cnt_last;
  logic [REGFILE_NSEL-1:0]  cnt_sel, cnt_next_sel;
  logic [REGFILE_WIDTH-1:0] next_word;
  logic                     out_of_range;
  logic                     xfer;

  rf_drain_idx_cnt #(
    .REGFILE_DEPTH (REGFILE_DEPTH),
    .REGFILE_NSEL  (REGFILE_NSEL)
  ) u_idx_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ce_i       (ce_i),
    .load_i     (cnt_load),
    .first_i    (first_sel_i),
    .last_i     (last_sel_i),
    .adv_i      (cnt_adv),
    .sel_o      (cnt_sel),
    .next_sel_o (cnt_next_sel),
    .last_o     (cnt_last)
  );

`ifdef RF_DRAIN_SNAPSHOT_EN
  logic [REGFILE_WIDTH-1:0] shadow_q [0:REGFILE_DEPTH-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < REGFILE_DEPTH; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (ce_i && (state_q == IDLE) && start_i) begin
      shadow_q <= regs_i;
    end
  end

  assign next_word = shadow_q[cnt_next_sel];
`else
  assign next_word = regs_i[cnt_next_sel];
`endif

  assign out_of_range = ({1'b0, first_sel_i} >= DEPTH_W) ||
                        ({1'b0, last_sel_i}  >= DEPTH_W);
  assign xfer = valid_q & ready_i;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = out_of_range;
          if (out_of_range) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_load = 1'b1;
            state_d  = STREAM;
            valid_d  = 1'b1;
            data_d   = regs_i[first_sel_i];
          end
        end
      end
      STREAM: begin
        if (xfer) begin
          if (cnt_last) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // The index advances and the next word loads on the same edge,
            // which sustains one word per cycle.
            cnt_adv = 1'b1;
            data_d  = next_word;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (ce_i) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ce_i) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = cnt_sel;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rf_drain_streamer.sv
module tb_rf_drain_streamer;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        start;
  logic [1:0]  first, last;
  logic [31:0] regs [0:3];
  logic        valid, ready, busy, done, err;
  logic [31:0] data;
  logic [1:0]  sel;

  logic        start5;
  logic [2:0]  first5, last5;
  logic [31:0] regs5 [0:4];
  logic        valid5, ready5, busy5, done5, err5;
  logic [31:0] data5;
  logic [2:0]  sel5;

  int unsigned total = 0;
  int unsigned bad   = 0;

  rf_drain_streamer #(
    .REGFILE_DEPTH (4),
    .REGFILE_WIDTH (32)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ce_i        (ce),
    .start_i     (start),
    .first_sel_i (first),
    .last_sel_i  (last),
    .regs_i      (regs),
    .valid_o     (valid),
    .ready_i     (ready),
    .data_o      (data),
    .sel_o       (sel),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  rf_drain_streamer #(
    .REGFILE_DEPTH (5),
    .REGFILE_WIDTH (32)
  ) u_dut5 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ce_i        (ce),
    .start_i     (start5),
    .first_sel_i (first5),
    .last_sel_i  (last5),
    .regs_i      (regs5),
    .valid_o     (valid5),
    .ready_i     (ready5),
    .data_o      (data5),
    .sel_o       (sel5),
    .busy_o      (busy5),
    .done_o      (done5),
    .err_o       (err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  first;
    logic [1:0]  last;
    int unsigned words;
    bit          bp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs_a();
    for (int i = 0; i < 4; i++) regs[i] = 32'hA000_0000 + i;
  endtask

  // Runs one drain on the depth-4 instance and checks every word, the
  // completion pulse and the return to idle.
  task automatic drain(input logic [1:0] f, input logic [1:0] l,
                       input int unsigned exp_words, input bit bp, input string tag);
    logic [1:0]  es;
    logic [31:0] ed;
    logic [31:0] snap [0:3];
    logic [4:0]  pat;
    int unsigned n, cyc;
    bit          x;
    pat = 5'b10010;
    for (int i = 0; i < 4; i++) snap[i] = regs[i];
    first = f;
    last  = l;
    start = 1'b1;
    ready = 1'b1;
    es = f;
    ed = regs[f];
    tick();
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      chk({tag, "_valid"}, valid, 1'b1);
      chk({tag, "_sel"},   sel,   es);
      chk({tag, "_data"},  data,  ed);
      chk({tag, "_busy"},  busy,  1'b1);
      ready = (bp && cyc < 5) ? pat[cyc] : 1'b1;
      if (bp) for (int i = 0; i < 4; i++) regs[i] = 32'hC000_0000 + cyc * 256 + i;
      x = ready;
      if (x && n + 1 < exp_words) begin
        es = es + 2'd1;
`ifdef RF_DRAIN_SNAPSHOT_EN
        ed = snap[es];
`else
        ed = regs[es];
`endif
      end
      tick();
      cyc++;
      if (x) n++;
    end
    chk({tag, "_words"}, n, exp_words);
    chk({tag, "_done"},  done,  1'b1);
    chk({tag, "_dvalid"}, valid, 1'b0);
    chk({tag, "_dbusy"}, busy,  1'b1);
    tick();
    chk({tag, "_done_end"}, done, 1'b0);
    chk({tag, "_idle"},     busy, 1'b0);
    set_regs_a();
  endtask

  initial begin
    logic [31:0] exp_w [0:3];
    logic [2:0]  exp5 [0:2];

    rst_n  = 1'b0;
    ce     = 1'b1;
    start  = 1'b0;
    first  = '0;
    last   = '0;
    ready  = 1'b1;
    start5 = 1'b0;
    first5 = '0;
    last5  = '0;
    ready5 = 1'b1;
    set_regs_a();
    for (int i = 0; i < 5; i++) regs5[i] = 32'h5000_0000 + i;

    vecs[0] = '{2'd1, 2'd2, 2, 1'b0};
    vecs[1] = '{2'd3, 2'd0, 2, 1'b0};
    vecs[2] = '{2'd2, 2'd2, 1, 1'b0};
    vecs[3] = '{2'd0, 2'd3, 4, 1'b1};
    vecs[4] = '{2'd2, 2'd1, 4, 1'b0};
    vecs[5] = '{2'd1, 2'd0, 4, 1'b1};

    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_err",   err,   1'b0);
    chk("rst_data",  data,  32'h0);
    chk("rst_sel",   sel,   2'd0);
    #11;
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    for (int v = 0; v < 6; v++) begin
      drain(vecs[v].first, vecs[v].last, vecs[v].words, vecs[v].bp,
            $sformatf("vec%0d", v));
    end

    // Clock enable low mid-stream, then again during DONE.
    first = 2'd0;
    last  = 2'd3;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ce_w0_sel", sel, 2'd0);
    tick();
    chk("ce_w1_sel", sel, 2'd1);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ce_hold_valid", valid, 1'b1);
      chk("ce_hold_sel",   sel,   2'd1);
      chk("ce_hold_data",  data,  32'hA000_0001);
      chk("ce_hold_busy",  busy,  1'b1);
    end
    ce = 1'b1;
    tick();
    chk("ce_w2_sel",  sel,  2'd2);
    chk("ce_w2_data", data, 32'hA000_0002);
    tick();
    chk("ce_w3_sel",  sel,  2'd3);
    tick();
    chk("ce_done",  done,  1'b1);
    chk("ce_valid", valid, 1'b0);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ce_done_stretch", done, 1'b1);
      chk("ce_done_busy",    busy, 1'b1);
    end
    ce = 1'b1;
    tick();
    chk("ce_done_end", done, 1'b0);
    chk("ce_idle",     busy, 1'b0);

    // Asynchronous reset between edges while a word is stalled.
    first = 2'd0;
    last  = 2'd3;
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ar_pre_valid", valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", valid, 1'b0);
    chk("ar_busy",  busy,  1'b0);
    chk("ar_done",  done,  1'b0);
    chk("ar_sel",   sel,   2'd0);
    chk("ar_data",  data,  32'h0);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("ar_no_done", done, 1'b0);
      chk("ar_no_busy", busy, 1'b0);
    end
    drain(2'd2, 2'd3, 2, 1'b0, "post_rst");

    // Entry 2 is overwritten after the start edge, before it is loaded.
    first = 2'd0;
    last  = 2'd3;
    ready = 1'b1;
    start = 1'b1;
    exp_w[0] = 32'hA000_0000;
    exp_w[1] = 32'hA000_0001;
`ifdef RF_DRAIN_SNAPSHOT_EN
    exp_w[2] = 32'hA000_0002;
`else
    exp_w[2] = 32'hDEAD_0002;
`endif
    exp_w[3] = 32'hA000_0003;
    tick();
    start = 1'b0;
    regs[2] = 32'hDEAD_0002;
    for (int k = 0; k < 4; k++) begin
      chk("snap_valid", valid, 1'b1);
      chk("snap_sel",   sel,   k[1:0]);
      chk("snap_data",  data,  exp_w[k]);
      tick();
    end
    chk("snap_done", done, 1'b1);
    tick();
    set_regs_a();

    // Depth 5: a wrapped range, then an out-of-range index, then recovery.
    exp5[0] = 3'd4;
    exp5[1] = 3'd0;
    exp5[2] = 3'd1;
    first5 = 3'd4;
    last5  = 3'd1;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("d5_valid", valid5, 1'b1);
      chk("d5_sel",   sel5,   exp5[k]);
      chk("d5_data",  data5,  32'h5000_0000 + exp5[k]);
      tick();
    end
    chk("d5_done", done5, 1'b1);
    chk("d5_err",  err5,  1'b0);
    tick();
    chk("d5_idle", busy5, 1'b0);

    first5 = 3'd0;
    last5  = 3'd6;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    chk("oor_err",   err5,   1'b1);
    chk("oor_valid", valid5, 1'b0);
    chk("oor_done",  done5,  1'b1);
    chk("oor_busy",  busy5,  1'b1);
    tick();
    chk("oor_done_end", done5,  1'b0);
    chk("oor_idle",     busy5,  1'b0);
    chk("oor_sticky",   err5,   1'b1);
    chk("oor_novalid",  valid5, 1'b0);

    first5 = 3'd1;
    last5  = 3'd1;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    chk("clr_err",   err5,   1'b0);
    chk("clr_valid", valid5, 1'b1);
    chk("clr_sel",   sel5,   3'd1);
    chk("clr_data",  data5,  32'h5000_0001);
    tick();
    chk("clr_done",  done5,  1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_drain_streamer.md
Name: rf_drain_streamer

Overview:
- Reader-side companion to the RC register file.
- On command, it walks a contiguous, wrap-around range of register-file entries.
- It presents each entry as one word on a valid/ready output stream toward the CGRA output/store path, then pulses done.
- It consumes the register file's parallel all-entries bus, so the register file needs no extra read port.

Parameters:
- REGFILE_DEPTH, 4, number of register-file entries (any value >= 2; not required to be a power of 2).
- REGFILE_NSEL, $clog2(REGFILE_DEPTH), index width.
- REGFILE_WIDTH, 32, data word width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- ce_i  in  1  clock enable; when low, all state is frozen and no handshake completes.
- start_i  in  1  drain request; sampled only in IDLE with ce_i=1.
- first_sel_i  in  REGFILE_NSEL  index of the first entry; captured on accepted start.
- last_sel_i  in  REGFILE_NSEL  index of the last entry (inclusive); captured on accepted start.
- regs_i  in  REGFILE_WIDTH x [0:REGFILE_DEPTH-1]  parallel register-file contents.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream ready.
- data_o  out  REGFILE_WIDTH  output word.
- sel_o  out  REGFILE_NSEL  index of the word on data_o.
- busy_o  out  1  high in STREAM and DONE.
- done_o  out  1  one-cycle pulse after the last word is transferred.
- err_o  out  1  sticky flag: an out-of-range index was captured; cleared by the next accepted start.

Behaviour:
- Reset (async assert, rst_ni=0): state=IDLE; valid_o, busy_o, done_o and err_o are 0; data_o and sel_o are 0; internal counters are 0. Release is synchronous to clk_i through the codebase's standard reset path.
- Reset mid-stream aborts immediately: no done_o, and the in-flight word is lost.
- States are IDLE, STREAM, DONE.
- IDLE -> STREAM on start_i & ce_i.
  - Capture the indices.
  - Compute remaining = ((last - first) mod REGFILE_DEPTH) + 1, so first==last gives 1 word.
  - Next cycle: valid_o=1, sel_o=first, data_o=regs_i[first] as sampled at the start edge (registered output, 1-cycle latency).
- STREAM: a transfer occurs on the edge where valid_o & ready_i & ce_i.
  - Words remain: sel_o advances to (sel+1 == REGFILE_DEPTH ? 0 : sel+1) and data_o loads the new entry on the same edge. Back-to-back transfers at 1 word/cycle are required.
  - Last word transferred: next cycle valid_o=0, done_o=1, state=DONE.
- Output stability: while valid_o=1 and no transfer occurs, data_o and sel_o stay stable even if regs_i changes (AXI-style hold rule).
- DONE: lasts one cycle with done_o=1 and busy_o=1, then goes to IDLE unconditionally. start_i in DONE or STREAM is ignored, not queued.
- Out-of-range indices (first_sel_i or last_sel_i >= REGFILE_DEPTH, possible only when REGFILE_DEPTH is not a power of 2):
  - Capture sets err_o=1.
  - The block goes directly to DONE with no words emitted and done_o pulsed.
- ce_i=0 holds every register, including done_o. A done pulse therefore stretches until the first ce_i=1 cycle.
- Width rules: the modular subtract is done in REGFILE_NSEL+1 bits. The remaining count is REGFILE_NSEL+1 bits wide so it can hold REGFILE_DEPTH.

Optional Feature:
- Macro: RF_DRAIN_SNAPSHOT_EN.
- Defined: on accepted start, all regs_i entries are copied into an internal shadow bank. The whole stream reads the shadow, so register-file writes during STREAM are invisible to the stream.
- Undefined: no shadow bank. Each word is sampled live from regs_i on the edge where it is loaded into data_o. Writes to not-yet-loaded entries during STREAM are visible.

Decomposition:
- Add to cgra_pkg:
  - typedef enum rf_drain_state_t {IDLE, STREAM, DONE}.
  - Nothing width-specific; widths stay parameters.
- One sub-module: rf_drain_idx_cnt, a wrap-around index counter with load (first), increment-on-transfer (modulo REGFILE_DEPTH), and a remaining-count/last flag.
- Data muxing and the FSM stay in the top module.

Test Plan:
- DEPTH=4, regs={A0,A1,A2,A3}, start with first=1, last=2, ready_i held 1 -> valid for 2 consecutive cycles carrying (sel 1,A1) then (sel 2,A2); done_o high in the following cycle; busy_o low the cycle after that.
- Wrap-around: first=3, last=0 -> words (3,A3), (0,A0); first==last=2 -> a single word (2,A2) then done.
- Backpressure: ready_i toggling 0,1,0,0,1 during a 4-word drain with regs_i changing every cycle -> data_o and sel_o stable whenever valid_o=1 and ready_i=0; exactly 4 transfers; done once.
- ce_i=0 for 3 cycles mid-stream and during DONE -> no transfer, state frozen, done_o stretched; resuming ce_i completes the drain normally.
- Async reset pulsed mid-stream (between clock edges) -> valid_o, busy_o and done_o drop to 0 immediately with no done pulse; a subsequent start works normally.
- DEPTH=5 variant: last=6 -> err_o=1, zero words, done_o pulse. With RF_DRAIN_SNAPSHOT_EN defined, overwriting entry 2 during a 0..3 drain -> the original entry-2 value is streamed.
